rf_access_scheduler: RTL and testbench

- Shares one register_block (16 warps x 16 regs x 16 lanes x 32 b; read ports 0/1, one write port, one shared warp_selector) between one operand-read requester (issue stage) and NUM_WB writeback requesters.
- Arbitrates each cycle and drives registered control, address and data to register_block.
- Returns read-response valid and tag aligned with register_block's combinational rdata.

---
 rtl/rf_sched_pkg.sv | 15 +
 rtl/rf_access_scheduler_if.sv | 54 +++++
 rtl/rf_access_scheduler_rr_arbiter.sv | 47 ++++
 rtl/rf_access_scheduler.sv | 142 ++++++++++++++
 tb/tb_rf_access_scheduler.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_sched_pkg.sv
// Shared geometry and types for the register-file access scheduler.
// lane_data_t carries one value per lane, with lane 0 in the LSBs.
package rf_sched_pkg;
  localparam int WARPS  = 16;
  localparam int REGS   = 16;
  localparam int LANES  = 16;
  localparam int DATA_W = 32;
  localparam int WARP_W = $clog2(WARPS);
  localparam int REG_W  = $clog2(REGS);

  typedef logic [WARP_W-1:0]       warp_id_t;
  typedef logic [REG_W-1:0]        reg_addr_t;
  typedef logic [LANES-1:0]        lane_mask_t;
  typedef logic [LANES*DATA_W-1:0] lane_data_t;
endpackage

// File: rtl/rf_access_scheduler_if.sv
// Requester and register_block signals of the scheduler.
// The slave modport is the scheduler side; the master modport is the requester side.
interface rf_access_scheduler_if #(
  parameter int NUM_WB = 2,
  parameter int TAG_W  = 4
);
  import rf_sched_pkg::*;

  logic                          rd_req_valid;
  logic                          rd_req_ready;
  warp_id_t                      rd_req_warp;
  reg_addr_t                     rd_req_src0;
  reg_addr_t                     rd_req_src1;
  logic                          rd_req_use0;
  logic                          rd_req_use1;
  lane_mask_t                    rd_req_mask;
  logic [TAG_W-1:0]              rd_req_tag;
  logic                          rd_rsp_valid;
  logic [TAG_W-1:0]              rd_rsp_tag;

  logic [NUM_WB-1:0]             wb_valid;
  logic [NUM_WB-1:0]             wb_ready;
  logic [NUM_WB*WARP_W-1:0]      wb_warp;
  logic [NUM_WB*REG_W-1:0]       wb_addr;
  logic [NUM_WB*LANES-1:0]       wb_mask;
  logic [NUM_WB*LANES*DATA_W-1:0] wb_data;

  warp_id_t                      rf_warp_selector;
  lane_mask_t                    rf_read_en_0;
  lane_mask_t                    rf_read_en_1;
  reg_addr_t                     rf_raddr_0;
  reg_addr_t                     rf_raddr_1;
  lane_mask_t                    rf_write_en;
  reg_addr_t                     rf_waddr;
  lane_data_t                    rf_wdata;

  modport slave (
    input  rd_req_valid, rd_req_warp, rd_req_src0, rd_req_src1,
           rd_req_use0, rd_req_use1, rd_req_mask, rd_req_tag,
           wb_valid, wb_warp, wb_addr, wb_mask, wb_data,
    output rd_req_ready, rd_rsp_valid, rd_rsp_tag, wb_ready,
           rf_warp_selector, rf_read_en_0, rf_read_en_1,
           rf_raddr_0, rf_raddr_1, rf_write_en, rf_waddr, rf_wdata
  );

  modport master (
    output rd_req_valid, rd_req_warp, rd_req_src0, rd_req_src1,
           rd_req_use0, rd_req_use1, rd_req_mask, rd_req_tag,
           wb_valid, wb_warp, wb_addr, wb_mask, wb_data,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_tag, wb_ready,
           rf_warp_selector, rf_read_en_0, rf_read_en_1,
           rf_raddr_0, rf_raddr_1, rf_write_en, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_access_scheduler_rr_arbiter.sv
// Round-robin pick among N requesters, one-hot grant.
// The pointer moves past the winner only when the caller actually grants.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % N);
      if (!grant_valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = IDX_W'((int'(grant_idx) + 1) % N);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/rf_access_scheduler.sv
// Shares one register_block between the operand-read requester and NUM_WB writebacks.
// Grants are combinational; register_block controls are registered, giving one cycle of read latency.
module rf_access_scheduler
  import rf_sched_pkg::*;
#(
  parameter int NUM_WB       = 2,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rf_access_scheduler_if.slave  bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int IDX_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  logic [NUM_WB-1:0] wb_onehot;
  logic [IDX_W-1:0]  wb_idx;
  logic              wb_any;
  warp_id_t          win_warp;
  reg_addr_t         win_addr;
  lane_mask_t        win_mask;
  lane_data_t        win_data;
  logic              compat, starve_mode, rd_gnt, wr_gnt;

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              rd_rsp_valid_q, rd_rsp_valid_d;
  logic [TAG_W-1:0]  rd_rsp_tag_q, rd_rsp_tag_d;
  warp_id_t          warp_sel_q, warp_sel_d;
  lane_mask_t        read_en_0_q, read_en_0_d, read_en_1_q, read_en_1_d;
  reg_addr_t         raddr_0_q, raddr_0_d, raddr_1_q, raddr_1_d;
  lane_mask_t        write_en_q, write_en_d;
  reg_addr_t         waddr_q, waddr_d;
  lane_data_t        wdata_q, wdata_d;

  rr_arbiter #(.N(NUM_WB)) u_rr_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (bus.wb_valid),
    .advance     (wr_gnt),
    .grant       (wb_onehot),
    .grant_idx   (wb_idx),
    .grant_valid (wb_any)
  );

  assign win_warp = bus.wb_warp[int'(wb_idx)*WARP_W +: WARP_W];
  assign win_addr = bus.wb_addr[int'(wb_idx)*REG_W +: REG_W];
  assign win_mask = bus.wb_mask[int'(wb_idx)*LANES +: LANES];
  assign win_data = bus.wb_data[int'(wb_idx)*LANES*DATA_W +: LANES*DATA_W];

  // Co-issue needs the shared warp selector to agree, and no read of the register
  // being written, since register_block would return its pre-write value.
  always_comb begin
    compat = (bus.rd_req_warp == win_warp)
           && !(bus.rd_req_use0 && (bus.rd_req_src0 == win_addr))
           && !(bus.rd_req_use1 && (bus.rd_req_src1 == win_addr));
    starve_mode = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (bus.rd_req_valid && wb_any) begin
      if (starve_mode) begin
        rd_gnt = 1'b1;
        wr_gnt = compat;
      end else begin
        wr_gnt = 1'b1;
        rd_gnt = compat;
      end
    end else begin
      rd_gnt = bus.rd_req_valid;
      wr_gnt = wb_any;
    end
  end

  assign bus.rd_req_ready = rd_gnt;
  assign bus.wb_ready     = wr_gnt ? wb_onehot : '0;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.rd_req_valid || rd_gnt) begin
      starve_cnt_d = '0;
    end else if (!starve_mode) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    rd_rsp_valid_d = rd_gnt;
    rd_rsp_tag_d   = rd_gnt ? bus.rd_req_tag : rd_rsp_tag_q;
    read_en_0_d    = (rd_gnt && bus.rd_req_use0) ? bus.rd_req_mask : '0;
    read_en_1_d    = (rd_gnt && bus.rd_req_use1) ? bus.rd_req_mask : '0;
    raddr_0_d      = rd_gnt ? bus.rd_req_src0 : raddr_0_q;
    raddr_1_d      = rd_gnt ? bus.rd_req_src1 : raddr_1_q;
    write_en_d     = wr_gnt ? win_mask : '0;
    waddr_d        = wr_gnt ? win_addr : waddr_q;
    wdata_d        = wr_gnt ? win_data : wdata_q;
    warp_sel_d     = warp_sel_q;
    if (rd_gnt) begin
      warp_sel_d = bus.rd_req_warp;
    end else if (wr_gnt) begin
      warp_sel_d = win_warp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q   <= '0;
      rd_rsp_valid_q <= 1'b0;
      rd_rsp_tag_q   <= '0;
      warp_sel_q     <= '0;
      read_en_0_q    <= '0;
      read_en_1_q    <= '0;
      raddr_0_q      <= '0;
      raddr_1_q      <= '0;
      write_en_q     <= '0;
      waddr_q        <= '0;
      wdata_q        <= '0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      rd_rsp_valid_q <= rd_rsp_valid_d;
      rd_rsp_tag_q   <= rd_rsp_tag_d;
      warp_sel_q     <= warp_sel_d;
      read_en_0_q    <= read_en_0_d;
      read_en_1_q    <= read_en_1_d;
      raddr_0_q      <= raddr_0_d;
      raddr_1_q      <= raddr_1_d;
      write_en_q     <= write_en_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
    end
  end

  assign bus.rd_rsp_valid     = rd_rsp_valid_q;
  assign bus.rd_rsp_tag       = rd_rsp_tag_q;
  assign bus.rf_warp_selector = warp_sel_q;
  assign bus.rf_read_en_0     = read_en_0_q;
  assign bus.rf_read_en_1     = read_en_1_q;
  assign bus.rf_raddr_0       = raddr_0_q;
  assign bus.rf_raddr_1       = raddr_1_q;
  assign bus.rf_write_en      = write_en_q;
  assign bus.rf_waddr         = waddr_q;
  assign bus.rf_wdata         = wdata_q;
endmodule

// File: tb/tb_rf_access_scheduler.sv
// Bench for rf_access_scheduler with a behavioural register_block and a read-response scoreboard.
module tb_rf_access_scheduler;
  import rf_sched_pkg::*;

  localparam int NUM_WB = 2;
  localparam int TAG_W  = 4;
  localparam int NV     = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_access_scheduler_if #(.NUM_WB(NUM_WB), .TAG_W(TAG_W)) bus();

  rf_access_scheduler #(.NUM_WB(NUM_WB), .TAG_W(TAG_W), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // register_block model: index = {warp, reg}
  lane_data_t mem [WARPS*REGS] = '{default: '0};
  always @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (bus.rf_write_en[l]) begin
        mem[{bus.rf_warp_selector, bus.rf_waddr}][l*DATA_W +: DATA_W] <= bus.rf_wdata[l*DATA_W +: DATA_W];
      end
    end
  end

  function automatic lane_data_t rd_port(input lane_mask_t en, input reg_addr_t a);
    lane_data_t r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      if (en[l]) r[l*DATA_W +: DATA_W] = mem[{bus.rf_warp_selector, a}][l*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  function automatic lane_data_t pat(input logic [7:0] s);
    lane_data_t r;
    for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = {s, 16'h0, 8'(k)};
    return r;
  endfunction

  typedef struct {
    logic rd_v; warp_id_t rwarp; reg_addr_t s0; reg_addr_t s1; logic u0; logic u1;
    lane_mask_t m; logic [TAG_W-1:0] tag;
    logic [1:0] wv; warp_id_t w0; reg_addr_t a0; lane_mask_t wm0;
    warp_id_t w1; reg_addr_t a1; lane_mask_t wm1; logic [7:0] seed;
    logic x_rd; logic [1:0] x_wb;
  } vec_t;

  typedef struct {
    logic [TAG_W-1:0] tag; lane_mask_t en0; lane_mask_t en1;
    reg_addr_t a0; reg_addr_t a1; warp_id_t warp; lane_data_t d0; lane_data_t d1;
  } rsp_t;

  vec_t       tbl [NV];
  rsp_t       sb_q [$];
  lane_data_t ref_mem [WARPS*REGS] = '{default: '0};
  logic       pend_v = 1'b0;
  logic [7:0] pend_idx;
  lane_mask_t pend_mask;
  lane_data_t pend_data;
  warp_id_t   exp_ws = '0;
  int         tests_run = 0;
  int         tests_failed = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.rd_req_valid = v.rd_v;
    bus.rd_req_warp  = v.rwarp;
    bus.rd_req_src0  = v.s0;
    bus.rd_req_src1  = v.s1;
    bus.rd_req_use0  = v.u0;
    bus.rd_req_use1  = v.u1;
    bus.rd_req_mask  = v.m;
    bus.rd_req_tag   = v.tag;
    bus.wb_valid     = v.wv;
    bus.wb_warp      = {v.w1, v.w0};
    bus.wb_addr      = {v.a1, v.a0};
    bus.wb_mask      = {v.wm1, v.wm0};
    bus.wb_data      = {pat(8'(v.seed + 8'd1)), pat(v.seed)};
  endtask

  // Scoreboard step, run once at every falling edge.
  task automatic sb_step();
    rsp_t e;
    logic [7:0] ri;
    if (!rst_n) begin
      sb_q.delete();
      pend_v = 1'b0;
      return;
    end
    if (bus.rd_rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("rsp_tag", bus.rd_rsp_tag, e.tag);
        check("rsp_en0", bus.rf_read_en_0, e.en0);
        check("rsp_en1", bus.rf_read_en_1, e.en1);
        check("rsp_raddr0", bus.rf_raddr_0, e.a0);
        check("rsp_raddr1", bus.rf_raddr_1, e.a1);
        check("rsp_warp", bus.rf_warp_selector, e.warp);
        check("rsp_rdata0", rd_port(bus.rf_read_en_0, bus.rf_raddr_0), e.d0);
        check("rsp_rdata1", rd_port(bus.rf_read_en_1, bus.rf_raddr_1), e.d1);
      end
    end
    if (pend_v) begin
      for (int l = 0; l < LANES; l++)
        if (pend_mask[l]) ref_mem[pend_idx][l*DATA_W +: DATA_W] = pend_data[l*DATA_W +: DATA_W];
      pend_v = 1'b0;
    end
    if (bus.rd_req_valid && bus.rd_req_ready) begin
      e.tag  = bus.rd_req_tag;
      e.en0  = bus.rd_req_use0 ? bus.rd_req_mask : '0;
      e.en1  = bus.rd_req_use1 ? bus.rd_req_mask : '0;
      e.a0   = bus.rd_req_src0;
      e.a1   = bus.rd_req_src1;
      e.warp = bus.rd_req_warp;
      e.d0   = '0;
      e.d1   = '0;
      for (int l = 0; l < LANES; l++) begin
        if (e.en0[l]) e.d0[l*DATA_W +: DATA_W] = ref_mem[{e.warp, e.a0}][l*DATA_W +: DATA_W];
        if (e.en1[l]) e.d1[l*DATA_W +: DATA_W] = ref_mem[{e.warp, e.a1}][l*DATA_W +: DATA_W];
      end
      sb_q.push_back(e);
    end
    for (int i = 0; i < NUM_WB; i++) begin
      if (bus.wb_valid[i] && bus.wb_ready[i]) begin
        ri        = {bus.wb_warp[i*WARP_W +: WARP_W], bus.wb_addr[i*REG_W +: REG_W]};
        pend_idx  = ri;
        pend_mask = bus.wb_mask[i*LANES +: LANES];
        pend_data = bus.wb_data[i*LANES*DATA_W +: LANES*DATA_W];
        pend_v    = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    sb_step();
  endtask

  // Registered outputs one cycle after table entry v was presented.
  task automatic check_prev(input vec_t v, input int i);
    lane_mask_t xm;
    reg_addr_t  xa;
    warp_id_t   xw;
    lane_data_t xd;
    if (v.x_wb[1]) begin
      xm = v.wm1; xa = v.a1; xw = v.w1; xd = pat(8'(v.seed + 8'd1));
    end else begin
      xm = v.wm0; xa = v.a0; xw = v.w0; xd = pat(v.seed);
    end
    check($sformatf("write_en[%0d]", i), bus.rf_write_en, (v.x_wb != 2'b00) ? xm : '0);
    if (v.x_wb != 2'b00) begin
      check($sformatf("waddr[%0d]", i), bus.rf_waddr, xa);
      check($sformatf("wdata[%0d]", i), bus.rf_wdata, xd);
    end
    if (v.x_rd) exp_ws = v.rwarp;
    else if (v.x_wb != 2'b00) exp_ws = xw;
    check($sformatf("warp_sel[%0d]", i), bus.rf_warp_selector, exp_ws);
    check($sformatf("rsp_valid[%0d]", i), bus.rd_rsp_valid, v.x_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t z;
    z = '{default: '0};
    // rd_v warp s0 s1 u0 u1 mask tag | wv w0 a0 wm0 w1 a1 wm1 seed | x_rd x_wb
    tbl[0]  = '{1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,16'h0000,4'h0, 2'b11,4'd1,4'd1,16'hFFFF,4'd2,4'd2,16'hFFFF,8'h10, 1'b0,2'b01};
    tbl[1]  = '{1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,16'h0000,4'h0, 2'b11,4'd1,4'd1,16'hFFFF,4'd2,4'd2,16'hFFFF,8'h11, 1'b0,2'b10};
    tbl[2]  = '{1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,16'h0000,4'h0, 2'b11,4'd1,4'd1,16'hFFFF,4'd2,4'd2,16'hFFFF,8'h12, 1'b0,2'b01};
    tbl[3]  = '{1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,16'h0000,4'h0, 2'b11,4'd1,4'd1,16'hFFFF,4'd2,4'd2,16'hFFFF,8'h13, 1'b0,2'b10};
    tbl[4]  = '{1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,16'h0000,4'h0, 2'b01,4'd3,4'd5,16'hFFFF,4'd0,4'd0,16'h0000,8'h00, 1'b0,2'b01};
    tbl[5]  = '{1'b1,4'd3,4'd5,4'd0,1'b1,1'b0,16'hFFFF,4'h1, 2'b00,4'd0,4'd0,16'h0000,4'd0,4'd0,16'h0000,8'h00, 1'b1,2'b00};
    tbl[6]  = '{1'b1,4'd2,4'd4,4'd0,1'b1,1'b0,16'hFFFF,4'h2, 2'b01,4'd2,4'd7,16'hFFFF,4'd0,4'd0,16'h0000,8'h20, 1'b1,2'b01};
    tbl[7]  = '{1'b1,4'd2,4'd4,4'd0,1'b1,1'b0,16'hFFFF,4'h3, 2'b01,4'd2,4'd4,16'hFFFF,4'd0,4'd0,16'h0000,8'h30, 1'b0,2'b01};
    tbl[8]  = '{1'b1,4'd2,4'd4,4'd0,1'b1,1'b0,16'hFFFF,4'h3, 2'b00,4'd0,4'd0,16'h0000,4'd0,4'd0,16'h0000,8'h00, 1'b1,2'b00};
    for (int k = 9; k < 13; k++)
      tbl[k] = '{1'b1,4'd5,4'd0,4'd0,1'b1,1'b0,16'hFFFF,4'h4, 2'b10,4'd0,4'd0,16'h0000,4'd6,4'd3,16'hFFFF,8'h40, 1'b0,2'b10};
    tbl[13] = '{1'b1,4'd5,4'd0,4'd0,1'b1,1'b0,16'hFFFF,4'h4, 2'b10,4'd0,4'd0,16'h0000,4'd6,4'd3,16'hFFFF,8'h40, 1'b1,2'b00};
    tbl[14] = '{1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,16'h0000,4'h0, 2'b10,4'd0,4'd0,16'h0000,4'd6,4'd3,16'hFFFF,8'h44, 1'b0,2'b10};
    tbl[15] = '{1'b1,4'd5,4'd0,4'd0,1'b1,1'b0,16'hFFFF,4'h7, 2'b10,4'd0,4'd0,16'h0000,4'd6,4'd3,16'hFFFF,8'h46, 1'b0,2'b10};
    tbl[16] = '{1'b1,4'd5,4'd0,4'd0,1'b1,1'b0,16'hFFFF,4'h7, 2'b00,4'd0,4'd0,16'h0000,4'd0,4'd0,16'h0000,8'h00, 1'b1,2'b00};
    tbl[17] = '{1'b1,4'd4,4'd9,4'd11,1'b1,1'b0,16'h00F0,4'hA, 2'b00,4'd0,4'd0,16'h0000,4'd0,4'd0,16'h0000,8'h00, 1'b1,2'b00};
    tbl[18] = '{1'b1,4'd4,4'd9,4'd11,1'b0,1'b0,16'hFFFF,4'h5, 2'b00,4'd0,4'd0,16'h0000,4'd0,4'd0,16'h0000,8'h00, 1'b1,2'b00};
    tbl[19] = '{1'b1,4'd8,4'd1,4'd2,1'b1,1'b1,16'hFFFF,4'h6, 2'b11,4'd8,4'd2,16'hFFFF,4'd8,4'd3,16'hFFFF,8'h50, 1'b0,2'b01};
    tbl[20] = '{1'b1,4'd8,4'd1,4'd2,1'b1,1'b1,16'hFFFF,4'h6, 2'b11,4'd8,4'd2,16'hFFFF,4'd8,4'd3,16'hFFFF,8'h52, 1'b1,2'b10};
    tbl[21] = z;
    tbl[22] = '{1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,16'h0000,4'h0, 2'b01,4'd9,4'd6,16'h0000,4'd0,4'd0,16'h0000,8'h60, 1'b0,2'b01};
    tbl[23] = '{1'b0,4'd0,4'd0,4'd0,1'b0,1'b0,16'h0000,4'h0, 2'b11,4'd9,4'd7,16'hFFFF,4'd10,4'd8,16'hFFFF,8'h62, 1'b0,2'b10};

    drive(z);
    #1;
    check("reset_write_en", bus.rf_write_en, 16'h0);
    check("reset_wdata", bus.rf_wdata, '0);
    check("reset_read_en", {bus.rf_read_en_0, bus.rf_read_en_1}, 32'h0);
    check("reset_addrs", {bus.rf_raddr_0, bus.rf_raddr_1, bus.rf_waddr, bus.rf_warp_selector}, 16'h0);
    check("reset_rsp", {bus.rd_rsp_valid, bus.rd_rsp_tag}, 5'h0);
    cyc();
    cyc();
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cyc();
      drive(tbl[i]);
      mid();
      if (i > 0) check_prev(tbl[i-1], i - 1);
      check($sformatf("rd_ready[%0d]", i), bus.rd_req_ready, tbl[i].x_rd);
      check($sformatf("wb_ready[%0d]", i), bus.wb_ready, tbl[i].x_wb);
      if (i == 13) check("starve_saturated", dut.starve_cnt_q, 3'd4);
      if (i == 14) check("starve_cleared", dut.starve_cnt_q, 3'd0);
    end
    cyc();
    drive(z);
    mid();
    check_prev(tbl[NV-1], NV - 1);

    // Reset while a granted write is on its way to register_block.
    cyc();
    z.wv = 2'b01; z.w0 = 4'd7; z.a0 = 4'd2; z.wm0 = 16'hFFFF; z.seed = 8'h70;
    drive(z);
    mid();
    check("rst_wb_ready", bus.wb_ready, 2'b01);
    cyc();
    z = '{default: '0};
    drive(z);
    check("rst_pre_write_en", bus.rf_write_en, 16'hFFFF);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_write_en", bus.rf_write_en, 16'h0);
    check("rst_async_warp_sel", bus.rf_warp_selector, 4'd0);
    mid();
    cyc();
    mid();
    cyc();
    rst_n = 1'b1;
    check("rst_no_write", mem[{4'd7, 4'd2}], '0);
    z.wv = 2'b11; z.w0 = 4'd1; z.a0 = 4'd9; z.wm0 = 16'hFFFF; z.w1 = 4'd2; z.a1 = 4'd9; z.wm1 = 16'hFFFF; z.seed = 8'h80;
    drive(z);
    mid();
    check("rst_rr_restart", bus.wb_ready, 2'b01);
    cyc();
    mid();
    check("rst_rr_next", bus.wb_ready, 2'b10);
    cyc();
    z = '{default: '0};
    drive(z);
    mid();
    cyc();
    mid();
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
